serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 187 ++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional parity, stop bit.
// A 2-flop synchronizer feeds a mid-bit sampling FSM with registered strobes.
`timescale 1ns/1ps
module serial_frame_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 CK,
  input  logic                 RB,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  output logic                 PERR,
  output logic                 FERR,
  output logic                 BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);
  localparam logic          PODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, rxs_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_pend_q, perr_pend_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 rxs;
  logic                 bit_tick;

  assign rxs      = sync2_q;
  assign bit_tick = (cnt_q == BIT_LAST);

  // Synchronizer and edge history reset to the idle-high line level.
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= RXD;
      sync2_q    <= sync1_q;
      rxs_prev_q <= rxs;
    end
  end

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (rxs_prev_q && !rxs) begin
          state_d = S_START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        // Mid start bit: a line that is high again was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d       = '0;
          bit_cnt_d   = '0;
          perr_pend_d = 1'b0;
          if (!rxs) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt_q == BW'(i)) shift_d[i] = rxs;
          end
          if (bit_cnt_q == BITS_LAST) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d       = '0;
          perr_pend_d = (^shift_q) ^ rxs ^ PODD;
          state_d     = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (rxs) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = perr_pend_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign DATA  = data_q;
  assign VALID = valid_q;
  assign PERR  = perr_q;
  assign FERR  = ferr_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized bench for serial_frame_rx with a frame-level reference model and
// a scoreboard queue drained by an independent output monitor.
`timescale 1ns/1ps
module tb_serial_frame_rx;

  localparam int DB   = 8;
  localparam int CPB  = 4;
  localparam int PEN  = 1;
  localparam int PODD = 0;
  // Start-bit launch to strobe: 2 sync flops + edge detect, half a bit, then
  // data, parity and stop bits at one bit time each.
  localparam int LAT  = 3 + CPB / 2 + (DB + PEN + 1) * CPB;

  logic          CK  = 1'b0;
  logic          RB  = 1'b0;
  logic          RXD = 1'b1;
  logic [DB-1:0] DATA;
  logic          VALID, PERR, FERR, BUSY;

  serial_frame_rx #(
    .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY_EN(PEN), .PARITY_ODD(PODD)
  ) dut (
    .CK(CK), .RB(RB), .RXD(RXD), .DATA(DATA),
    .VALID(VALID), .PERR(PERR), .FERR(FERR), .BUSY(BUSY)
  );

  always #10 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct {
    bit            is_valid;
    logic [DB-1:0] data;
    bit            perr;
    int            t0;
  } exp_t;

  exp_t          sbq[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  logic [DB-1:0] model_data = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive_bit(input logic b);
    RXD = b;
    repeat (CPB) @(posedge CK);
    #1;
  endtask

  // Called at 1 ns after a rising edge; returns aligned the same way.
  task automatic send_frame(input logic [DB-1:0] d, input logic pbit,
                            input logic stop, input int hold_bits);
    exp_t e;
    e.t0 = cyc;
    if (stop) begin
      e.is_valid = 1'b1;
      e.data     = d;
      e.perr     = (PEN != 0) && ((($countones(d) + int'(pbit) + PODD) % 2) != 0);
      model_data = d;
    end else begin
      e.is_valid = 1'b0;
      e.data     = model_data;
      e.perr     = 1'b0;
    end
    sbq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PEN != 0) drive_bit(pbit);
    drive_bit(stop);
    if (!stop) begin
      repeat (hold_bits) drive_bit(1'b0);
      chk("busy_in_wait_high", BUSY, 1);
      drive_bit(1'b1);
      chk("busy_after_line_high", BUSY, 0);
    end
  endtask

  function automatic logic even_par(input logic [DB-1:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Output monitor: pops one expectation per VALID or FERR strobe.
  exp_t e_mon;
  logic prev_v = 1'b0, prev_p = 1'b0, prev_f = 1'b0, prev_b = 1'b0;
  always @(negedge CK) begin
    if (!RB) begin
      prev_v = 1'b0; prev_p = 1'b0; prev_f = 1'b0; prev_b = 1'b0;
    end else begin
      if (VALID || FERR || PERR) begin
        chk("valid_ferr_exclusive", VALID & FERR, 0);
        chk("perr_only_with_valid", PERR & ~VALID, 0);
        chk("strobe_width", (VALID & prev_v) | (FERR & prev_f) | (PERR & prev_p), 0);
        chk("strobe_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e_mon = sbq.pop_front();
          chk("strobe_kind", VALID, e_mon.is_valid);
          chk("data", DATA, e_mon.data);
          chk("perr", PERR, e_mon.perr);
          chk("latency", cyc - e_mon.t0, LAT);
          chk("busy_at_strobe", BUSY, !e_mon.is_valid);
          chk("busy_before_strobe", prev_b, 1);
        end
      end
      prev_v = VALID; prev_p = PERR; prev_f = FERR; prev_b = BUSY;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] rd;
    logic          rp, rs;
    // Reset held while the line toggles: every output must stay quiet.
    #5;
    for (int i = 0; i < 5; i++) begin
      #10 RXD = ~RXD;
      chk("reset_outputs", {DATA, VALID, PERR, FERR, BUSY}, 0);
    end
    RXD = 1'b1;
    RB  = 1'b1;
    @(posedge CK); #1;
    repeat (2) drive_bit(1'b1);

    send_frame(8'hA5, 1'b0, 1'b1, 0);
    repeat (2) drive_bit(1'b1);

    // One-cycle glitch: BUSY rises, then drops at the start-bit check.
    RXD = 1'b0;
    @(posedge CK); #1;
    RXD = 1'b1;
    repeat (2) @(posedge CK);
    #1 chk("glitch_busy_high", BUSY, 1);
    repeat (2 * CPB) @(posedge CK);
    #1 chk("glitch_busy_low", BUSY, 0);
    send_frame(8'h01, even_par(8'h01), 1'b1, 0);
    drive_bit(1'b1);

    send_frame(8'h3C, 1'b1, 1'b1, 0);
    drive_bit(1'b1);
    send_frame(8'h55, even_par(8'h55), 1'b0, 3);
    drive_bit(1'b1);

    // Reset in the middle of data bit 3 of an all-ones frame.
    drive_bit(1'b0);
    repeat (3) drive_bit(1'b1);
    RXD = 1'b1;
    repeat (CPB / 2) @(posedge CK);
    #1 RB = 1'b0;
    model_data = '0;
    repeat (2) @(posedge CK);
    #1 chk("midframe_reset_outputs", {DATA, VALID, PERR, FERR, BUSY}, 0);
    RB = 1'b1;
    repeat (2) drive_bit(1'b1);
    send_frame(8'h81, even_par(8'h81), 1'b1, 0);
    send_frame(8'h7E, even_par(8'h7E), 1'b1, 0);
    drive_bit(1'b1);

    for (int n = 0; n < 24; n++) begin
      rd = DB'($urandom);
      rp = even_par(rd) ^ logic'($urandom_range(0, 3) == 0);
      rs = logic'($urandom_range(0, 4) != 0);
      send_frame(rd, rp, rs, $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) drive_bit(1'b1);
    end

    repeat (4) drive_bit(1'b1);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("idle_busy", BUSY, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
